// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front end.
// Contents: PS/2 scancodes, keyboard key-register indices, rotate and coin-FSM enums,
// scancode decoder, joystick-word bit index helpers and the direction rotator.
package arcade_input_pkg;

    // PS/2 set-2 scancodes; bit 8 carries the E0 prefix.
    localparam logic [8:0] ScUp    = 9'h175;
    localparam logic [8:0] ScDown  = 9'h172;
    localparam logic [8:0] ScLeft  = 9'h16B;
    localparam logic [8:0] ScRight = 9'h174;
    localparam logic [8:0] ScSpace = 9'h029;
    localparam logic [8:0] ScCtrl  = 9'h014;
    localparam logic [8:0] ScAlt   = 9'h011;
    localparam logic [8:0] ScF1    = 9'h005;
    localparam logic [8:0] Sc1     = 9'h016;
    localparam logic [8:0] ScF2    = 9'h006;
    localparam logic [8:0] Sc2     = 9'h01E;
    localparam logic [8:0] Sc5     = 9'h02E;

    // Bit positions inside the key register vector.
    localparam int unsigned KeyUp    = 0;
    localparam int unsigned KeyDown  = 1;
    localparam int unsigned KeyLeft  = 2;
    localparam int unsigned KeyRight = 3;
    localparam int unsigned KeySpace = 4;
    localparam int unsigned KeyCtrl  = 5;
    localparam int unsigned KeyAlt   = 6;
    localparam int unsigned KeyF1    = 7;
    localparam int unsigned Key1     = 8;
    localparam int unsigned KeyF2    = 9;
    localparam int unsigned Key2     = 10;
    localparam int unsigned Key5     = 11;
    localparam int unsigned NumKeys  = 12;

    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;

    typedef enum logic [1:0] {StIdle, StPulse, StGap} coin_state_e;

    // One-hot (or zero) match of a scancode against the key set.
    // Arrows ignore the E0 bit so numpad arrows behave the same.
    function automatic logic [NumKeys-1:0] key_decode(input logic [8:0] code);
        logic [NumKeys-1:0] hit;
        hit           = '0;
        hit[KeyUp]    = (code[7:0] == ScUp[7:0]);
        hit[KeyDown]  = (code[7:0] == ScDown[7:0]);
        hit[KeyLeft]  = (code[7:0] == ScLeft[7:0]);
        hit[KeyRight] = (code[7:0] == ScRight[7:0]);
        hit[KeySpace] = (code == ScSpace);
        hit[KeyCtrl]  = (code == ScCtrl);
        hit[KeyAlt]   = (code == ScAlt);
        hit[KeyF1]    = (code == ScF1);
        hit[Key1]     = (code == Sc1);
        hit[KeyF2]    = (code == ScF2);
        hit[Key2]     = (code == Sc2);
        hit[Key5]     = (code == Sc5);
        return hit;
    endfunction

    function automatic logic [3:0] joy_btn_idx(input int unsigned k);
        return 4'(4 + k);
    endfunction

    function automatic logic [3:0] joy_coin_idx(input int unsigned nbuttons);
        return 4'(4 + nbuttons);
    endfunction

    function automatic logic [3:0] joy_start_idx(input int unsigned nbuttons);
        return 4'(5 + nbuttons);
    endfunction

    // d = {up, down, left, right}
    function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e rot);
        logic [3:0] r;
        unique case (rot)
            ROT_90:  r = {d[1], d[0], d[2], d[3]};  // up<-left, down<-right, left<-down, right<-up
            ROT_180: r = {d[2], d[3], d[0], d[1]};
            ROT_270: r = {d[0], d[1], d[3], d[2]};  // up<-right, down<-left, left<-up, right<-down
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Player-input bus between hps_io-side logic and the mapper.
// master: drives ps2_key, joy_in, rotate, auto_coin, autofire_en; reads mapped outputs.
// slave : the mapper; reads the raw inputs, drives dir_out, btn_out, start_out, coin_out.
interface arcade_input_mapper_if #(
    parameter int unsigned PLAYERS  = 2,
    parameter int unsigned NBUTTONS = 1
);
    logic [10:0]               ps2_key;
    logic [16*PLAYERS-1:0]     joy_in;
    logic [1:0]                rotate;
    logic                      auto_coin;
    logic [PLAYERS-1:0]        autofire_en;
    logic [4*PLAYERS-1:0]      dir_out;
    logic [NBUTTONS*PLAYERS-1:0] btn_out;
    logic [PLAYERS-1:0]        start_out;
    logic                      coin_out;

    modport master (
        output ps2_key, joy_in, rotate, auto_coin, autofire_en,
        input  dir_out, btn_out, start_out, coin_out
    );

    modport slave (
        input  ps2_key, joy_in, rotate, auto_coin, autofire_en,
        output dir_out, btn_out, start_out, coin_out
    );
endinterface

// File: rtl/input_coin_pulser.sv
// Coin pulse generator: turns request rising edges into COIN_PULSE-cycle pulses separated by
// at least COIN_PULSE low cycles, with one pending request remembered while busy.
// Ports: clk_sys, I_RESETn (sync, active-low), req (level request), coin_out (registered pulse),
//        busy (FSM will be outside IDLE in the coming cycle).
module input_coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 1228800,
    parameter int unsigned CNT_W      = $clog2(COIN_PULSE + 1)
) (
    input  logic clk_sys,
    input  logic I_RESETn,
    input  logic req,
    output logic coin_out,
    output logic busy
);

    localparam logic [CNT_W-1:0] Reload = CNT_W'(COIN_PULSE - 1);

    coin_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             req_q;
    logic             coin_q;
    logic             req_edge;

    assign req_edge = req & ~req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (req_edge) begin
                    state_d = StPulse;
                    cnt_d   = Reload;
                end
            end
            StPulse: begin
                if (req_edge) pend_d = 1'b1;  // a second pending edge is simply lost
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = Reload;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    if (pend_q || req_edge) begin
                        state_d = StPulse;
                        cnt_d   = Reload;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (req_edge) pend_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!I_RESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            coin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            req_q   <= req;
            coin_q  <= (state_d == StPulse);
        end
    end

    assign coin_out = coin_q;
    // Looks one cycle ahead so a registered consumer releases exactly as the FSM reaches IDLE.
    assign busy     = (state_d != StIdle);

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: decodes PS/2 key events, ORs them with per-player joystick words,
// rotates directions, applies per-player autofire on button 0 and drives the coin pulser.
// Ports: clk_sys (only clock), I_RESETn (sync, active-low), bus_io (slave side of the input
//        bus: ps2_key, joy_in, rotate, auto_coin, autofire_en in; dir/btn/start/coin out).
// All outputs are registered and active-high.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS      = 2,
    parameter int unsigned NBUTTONS     = 1,
    parameter int unsigned COIN_PULSE   = 1228800,
    parameter int unsigned AUTOFIRE_DIV = 1228800
) (
    input logic                  clk_sys,
    input logic                  I_RESETn,
    arcade_input_mapper_if.slave bus_io
);

    localparam int unsigned CntMax = (COIN_PULSE > AUTOFIRE_DIV) ? COIN_PULSE : AUTOFIRE_DIV;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] AfLast = CntW'(AUTOFIRE_DIV - 1);

    // Keyboard key registers
    logic               tog_q;
    logic [NumKeys-1:0] keys_q, keys_d, key_hit;
    logic               key_event;

    assign key_event = bus_io.ps2_key[10] ^ tog_q;
    assign key_hit   = key_decode(bus_io.ps2_key[8:0]);

    always_comb begin
        keys_d = keys_q;
        if (key_event) begin
            for (int i = 0; i < int'(NumKeys); i++) begin
                if (key_hit[i]) keys_d[i] = bus_io.ps2_key[9];
            end
        end
    end

    // Per-player merge, rotation and autofire
    logic [4*PLAYERS-1:0]        dir_m;
    logic [NBUTTONS*PLAYERS-1:0] btn_m;
    logic [PLAYERS-1:0]          start_m;
    logic [PLAYERS-1:0]          coin_m;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0]         joy;
        logic [3:0]          kdir;
        logic [NBUTTONS-1:0] kbtn;
        logic                kstart;
        logic [NBUTTONS-1:0] btn_p, btn_fin;
        logic                held, held_q;
        logic                phase_q, phase_d;
        logic [CntW-1:0]     af_cnt_q, af_cnt_d;
        logic                unused_joy;

        assign joy        = bus_io.joy_in[16*p +: 16];
        assign unused_joy = ^joy[15:6+NBUTTONS];

        if (p == 0) begin : g_kb_p0
            assign kdir   = {keys_q[KeyUp], keys_q[KeyDown], keys_q[KeyLeft], keys_q[KeyRight]};
            // Alt drops out by truncation when there is only one button.
            assign kbtn   = NBUTTONS'({keys_q[KeyAlt], keys_q[KeySpace] | keys_q[KeyCtrl]});
            assign kstart = keys_q[KeyF1] | keys_q[Key1];
        end else if (p == 1) begin : g_kb_p1
            assign kdir   = '0;
            assign kbtn   = '0;
            assign kstart = keys_q[KeyF2] | keys_q[Key2];
        end else begin : g_kb_none
            assign kdir   = '0;
            assign kbtn   = '0;
            assign kstart = 1'b0;
        end

        for (genvar k = 0; k < NBUTTONS; k++) begin : g_btn
            assign btn_p[k] = joy[joy_btn_idx(k)] | kbtn[k];
        end

        assign dir_m[4*p +: 4] = rotate_dir(joy[3:0] | kdir, rot_e'(bus_io.rotate));
        assign start_m[p]      = joy[joy_start_idx(NBUTTONS)] | kstart;
        assign coin_m[p]       = joy[joy_coin_idx(NBUTTONS)];
        assign held            = btn_p[0];

        always_comb begin
            phase_d  = phase_q;
            af_cnt_d = af_cnt_q;
            if (held && !held_q) begin
                phase_d  = 1'b1;
                af_cnt_d = '0;
            end else if (held) begin
                if (af_cnt_q == AfLast) begin
                    af_cnt_d = '0;
                    phase_d  = ~phase_q;
                end else begin
                    af_cnt_d = af_cnt_q + 1'b1;
                end
            end
        end

        always_comb begin
            btn_fin = btn_p;
            if (bus_io.autofire_en[p]) btn_fin[0] = held & phase_d;
        end

        assign btn_m[p*NBUTTONS +: NBUTTONS] = btn_fin;

        always_ff @(posedge clk_sys) begin
            if (!I_RESETn) begin
                held_q   <= 1'b0;
                phase_q  <= 1'b1;
                af_cnt_q <= '0;
            end else begin
                held_q   <= held;
                phase_q  <= phase_d;
                af_cnt_q <= af_cnt_d;
            end
        end
    end

    // Coin request and free-play start masking
    logic [PLAYERS-1:0] start_prev_q;
    logic               start_edge;
    logic               coin_req_d, coin_req_q;
    logic               coin_busy, coin_w;
    logic               start_mask;

    assign start_edge = |(start_m & ~start_prev_q);
    assign coin_req_d = (|coin_m) | keys_q[Key5] | (bus_io.auto_coin & start_edge);
    // coin_req_d covers the cycle before the pulser sees the request.
    assign start_mask = bus_io.auto_coin & (coin_busy | coin_req_d);

    input_coin_pulser #(
        .COIN_PULSE (COIN_PULSE),
        .CNT_W      (CntW)
    ) u_coin (
        .clk_sys  (clk_sys),
        .I_RESETn (I_RESETn),
        .req      (coin_req_q),
        .coin_out (coin_w),
        .busy     (coin_busy)
    );

    // Output registers
    logic [4*PLAYERS-1:0]        dir_q;
    logic [NBUTTONS*PLAYERS-1:0] btn_q;
    logic [PLAYERS-1:0]          start_q;

    always_ff @(posedge clk_sys) begin
        if (!I_RESETn) begin
            tog_q        <= bus_io.ps2_key[10];  // no phantom event when reset is released
            keys_q       <= '0;
            start_prev_q <= '0;
            coin_req_q   <= 1'b0;
            dir_q        <= '0;
            btn_q        <= '0;
            start_q      <= '0;
        end else begin
            tog_q        <= bus_io.ps2_key[10];
            keys_q       <= keys_d;
            start_prev_q <= start_m;
            coin_req_q   <= coin_req_d;
            dir_q        <= dir_m;
            btn_q        <= btn_m;
            start_q      <= start_m & ~{PLAYERS{start_mask}};
        end
    end

    assign bus_io.dir_out   = dir_q;
    assign bus_io.btn_out   = btn_q;
    assign bus_io.start_out = start_q;
    assign bus_io.coin_out  = coin_w;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper (PLAYERS=2, NBUTTONS=1, COIN_PULSE=8,
// AUTOFIRE_DIV=4): table-driven joystick/rotation vectors, a keyboard table, and hand-written
// coin, free-play, autofire and reset sequences.
module tb_arcade_input_mapper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tog = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    arcade_input_mapper_if #(.PLAYERS(2), .NBUTTONS(1)) bus ();

    arcade_input_mapper #(
        .PLAYERS      (2),
        .NBUTTONS     (1),
        .COIN_PULSE   (8),
        .AUTOFIRE_DIV (4)
    ) dut (
        .clk_sys  (clk),
        .I_RESETn (rst_n),
        .bus_io   (bus)
    );

    typedef struct {
        logic [1:0]  rot;
        logic [31:0] joy;
        logic [7:0]  dir;
        logic [1:0]  btn;
        logic [1:0]  start;
    } vec_t;

    typedef struct {
        logic [8:0] code;
        logic [7:0] dir;
        logic [1:0] btn;
        logic [1:0] start;
    } key_t;

    vec_t vecs[9];
    key_t keys[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic key_event(input logic pressed, input logic [8:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, code};
    endtask

    task automatic check_all(input string name, input logic [7:0] dir, input logic [1:0] btn,
                             input logic [1:0] start, input logic coin);
        check({name, "_dir"}, 32'(bus.dir_out), 32'(dir));
        check({name, "_btn"}, 32'(bus.btn_out), 32'(btn));
        check({name, "_start"}, 32'(bus.start_out), 32'(start));
        check({name, "_coin"}, 32'(bus.coin_out), 32'(coin));
    endtask

    initial begin
        // {rotate, joy_in, dir_out, btn_out, start_out}
        vecs[0] = '{2'd0, 32'h0001_0008, 8'h18, 2'b00, 2'b00};
        vecs[1] = '{2'd1, 32'h0002_0008, 8'h81, 2'b00, 2'b00};
        vecs[2] = '{2'd1, 32'h0001_0004, 8'h42, 2'b00, 2'b00};
        vecs[3] = '{2'd2, 32'h0000_000A, 8'h05, 2'b00, 2'b00};
        vecs[4] = '{2'd3, 32'h0001_0008, 8'h82, 2'b00, 2'b00};
        vecs[5] = '{2'd3, 32'h0002_0004, 8'h41, 2'b00, 2'b00};
        vecs[6] = '{2'd0, 32'h0040_0010, 8'h00, 2'b01, 2'b10};
        vecs[7] = '{2'd0, 32'h0010_0040, 8'h00, 2'b10, 2'b01};
        vecs[8] = '{2'd0, 32'h0000_0000, 8'h00, 2'b00, 2'b00};

        // {scancode, dir_out, btn_out, start_out} while held, rotate=0
        keys[0] = '{9'h175, 8'h08, 2'b00, 2'b00};
        keys[1] = '{9'h06B, 8'h02, 2'b00, 2'b00};
        keys[2] = '{9'h029, 8'h00, 2'b01, 2'b00};
        keys[3] = '{9'h014, 8'h00, 2'b01, 2'b00};
        keys[4] = '{9'h006, 8'h00, 2'b00, 2'b10};
        keys[5] = '{9'h01C, 8'h00, 2'b00, 2'b00};
        keys[6] = '{9'h105, 8'h00, 2'b00, 2'b00};

        bus.ps2_key     = '0;
        bus.joy_in      = '0;
        bus.rotate      = 2'd0;
        bus.auto_coin   = 1'b0;
        bus.autofire_en = '0;

        step();
        step();
        check_all("reset", 8'h00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        step();

        // Joystick merge and rotation, 1-cycle latency
        for (int i = 0; i < 9; i++) begin
            bus.rotate = vecs[i].rot;
            bus.joy_in = vecs[i].joy;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].dir, vecs[i].btn, vecs[i].start, 1'b0);
        end

        // Keyboard: nothing after 1 cycle, mapped after 2, cleared after release
        for (int i = 0; i < 7; i++) begin
            key_event(1'b1, keys[i].code);
            step();
            check_all($sformatf("key%0d_lat", i), 8'h00, 2'b00, 2'b00, 1'b0);
            step();
            check_all($sformatf("key%0d_on", i), keys[i].dir, keys[i].btn, keys[i].start, 1'b0);
            key_event(1'b0, keys[i].code);
            step();
            step();
            check_all($sformatf("key%0d_off", i), 8'h00, 2'b00, 2'b00, 1'b0);
        end

        // Up arrow with quarter rotation shows as right
        bus.rotate = 2'd1;
        key_event(1'b1, 9'h175);
        step();
        step();
        check("key_rot90", 32'(bus.dir_out), 32'h01);
        key_event(1'b0, 9'h075);
        step();
        step();
        check("key_rot90_off", 32'(bus.dir_out), 32'h00);
        bus.rotate = 2'd0;
        step();

        // Coin: edges sampled at E0 (held 3), E5 (pending), E7 (dropped)
        for (int k = 0; k <= 40; k++) begin
            bus.joy_in = (k <= 2 || k == 5 || k == 7) ? 32'h20 : 32'h0;
            step();
            check($sformatf("coin_k%0d", k), 32'(bus.coin_out),
                  32'(((k >= 1 && k <= 8) || (k >= 17 && k <= 24)) ? 1 : 0));
        end

        // Free play: held start gives one coin, start visible once the FSM is idle again
        bus.auto_coin = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            bus.joy_in = 32'h40;
            step();
            check($sformatf("fp_coin_k%0d", k), 32'(bus.coin_out),
                  32'((k >= 1 && k <= 8) ? 1 : 0));
            check($sformatf("fp_start_k%0d", k), 32'(bus.start_out),
                  32'((k >= 17) ? 1 : 0));
        end
        bus.joy_in = '0;
        bus.auto_coin = 1'b0;
        step();
        step();

        // Autofire on player 0 button 0
        bus.autofire_en = 2'b01;
        for (int k = 0; k < 20; k++) begin
            bus.joy_in = 32'h10;
            step();
            check($sformatf("af_k%0d", k), 32'(bus.btn_out), 32'(((k / 4) % 2 == 0) ? 1 : 0));
        end
        bus.joy_in = '0;
        step();
        check("af_release", 32'(bus.btn_out), 32'h0);
        bus.autofire_en = '0;
        step();

        // Reset mid-pulse with a key held and the toggle flipped during reset
        key_event(1'b1, 9'h175);
        step();
        step();
        check("rst_pre_dir", 32'(bus.dir_out), 32'h08);
        bus.joy_in = 32'h20;
        step();
        bus.joy_in = '0;
        step();
        step();
        check("rst_pre_coin", 32'(bus.coin_out), 32'h1);
        tog = ~tog;
        bus.ps2_key = {tog, 1'b1, 9'h175};
        rst_n = 1'b0;
        step();
        check_all("rst_mid", 8'h00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("rst_post_dir%0d", k), 32'(bus.dir_out), 32'h0);
            check($sformatf("rst_post_coin%0d", k), 32'(bus.coin_out), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end between `hps_io` and an arcade core. It decodes PS/2 key events, merges them with per-player joystick words, and applies one of four screen rotations. It generates arcade-legal coin pulses (fixed width, enforced gap, optional free-play coin-on-start) and optional per-player autofire. All outputs are registered and active-high; the core top inverts them where its inputs are active-low.

## Interface
- `PLAYERS`, 2, number of players (1..4).
- `NBUTTONS`, 1, action buttons per player (1..8).
- `COIN_PULSE`, 1228800, coin high time and minimum low gap, in `clk_sys` cycles (50 ms at 24.576 MHz).
- `AUTOFIRE_DIV`, 1228800, autofire half-period in cycles.

- `clk_sys`  in  1  system clock; the only clock.
- `I_RESETn`  in  1  reset, synchronous, active-low.
- `ps2_key`  in  11  [10] event toggle, [9] pressed, [8:0] scancode (bit 8 = E0 prefix).
- `joy_in`  in  16*PLAYERS  per-player joystick word; player p at [16p+15:16p].
- `rotate`  in  2  0 none, 1 quarter (horizontal), 2 half, 3 three-quarter.
- `auto_coin`  in  1  free play: a start press generates a coin.
- `autofire_en`  in  PLAYERS  per-player autofire on button 0.
- `dir_out`  out  4*PLAYERS  {up,down,left,right} per player.
- `btn_out`  out  NBUTTONS*PLAYERS  action buttons.
- `start_out`  out  PLAYERS  start buttons.
- `coin_out`  out  1  stretched coin pulse.

## Operation
- Joystick word layout: [0] right, [1] left, [2] down, [3] up, [4+k] button k, [4+NBUTTONS] coin, [5+NBUTTONS] start.
- Keyboard events:
  - An event is `ps2_key[10]` differing from its registered copy.
  - Matching key register takes `ps2_key[9]`.
  - Arrows `X75/X72/X6B/X74` match with the E0 bit ignored.
  - Space `029` or Ctrl `014` → P1 button 0; Alt `011` → P1 button 1 (if NBUTTONS>1).
  - F1 `005` / `1` `016` → start 0; F2 `006` / `2` `01E` → start 1 (if PLAYERS>1).
  - `5` `02E` → coin.
  - Unlisted codes are ignored.
- Keyboard directions and buttons OR into player 0 only.
- Rotation is applied per player after the merge:
  - rotate=1: up←left, down←right, left←down, right←up.
  - rotate=2: up↔down, left↔right.
  - rotate=3: up←right, down←left, left←up, right←down.
- Coin FSM, states IDLE, PULSE, GAP:
  - Request = any joystick coin | key coin | (`auto_coin` & rising edge of any merged start).
  - IDLE + request rising edge → PULSE; counter loads COIN_PULSE−1; `coin_out`=1.
  - PULSE at count 0 → GAP; counter reloads; `coin_out`=0.
  - GAP at count 0 → IDLE, or directly back to PULSE if a request edge is pending.
  - Pending depth is 1; further edges during PULSE/GAP are dropped.
  - A held request never retriggers.
- `start_out[p]` = merged start & ~(`auto_coin` & FSM≠IDLE). In free play, start is seen only after the coin has completed.
- Autofire, per player:
  - With `autofire_en[p]`, `btn_out` bit 0 = held & phase.
  - A rising edge of held sets phase=1 and clears the counter.
  - phase toggles every AUTOFIRE_DIV cycles while held.
  - Disabled: button passes through.

## Timing
- Reset (`I_RESETn`=0 at a `clk_sys` edge) sets:
  - all outputs 0;
  - key registers 0;
  - FSM IDLE, pending 0;
  - counters 0, phases 1;
  - toggle copy ← `ps2_key[10]`, so no event fires on release of reset.
- Reset mid-pulse drops `coin_out` on the next edge.
- Latency:
  - joystick → outputs: 1 cycle.
  - keyboard event → key register 1 cycle; → outputs 2 cycles.
  - request edge → `coin_out`: 2 cycles.
- `coin_out` is high exactly COIN_PULSE cycles. The minimum low time between pulses is COIN_PULSE cycles.
- Same-cycle press and release of different keys are impossible (one event per toggle); joystick and keyboard are ORed, never prioritised.
- `rotate` changes take effect on the next cycle; no glitch filtering.
- Counter widths are $clog2(max(COIN_PULSE,AUTOFIRE_DIV)+1). Counters never wrap; each reloads on terminal count.

## Structure
- Package `arcade_input_pkg`:
  - PS/2 scancode localparams;
  - rotate enum (ROT_0, ROT_90, ROT_180, ROT_270);
  - coin FSM state enum;
  - functions returning joystick bit indices for a given NBUTTONS.
- Sub-module `input_coin_pulser` (params COIN_PULSE): ports `clk_sys`, `I_RESETn`, `req`, `coin_out`, `busy`. Holds the FSM, counter and pending bit.
- Autofire is a generate loop over players inside the top.

## Test plan
- Key event (COIN_PULSE=8, AUTOFIRE_DIV=4): toggle `ps2_key` to {1,1,0x175} → `dir_out[3]`=1 two cycles later; then {0,0,0x075} → 0. Rotate=1: same press → `dir_out[0]` (right).
- Coin: `joy_in[5]` high for 3 cycles → `coin_out` high 8 cycles starting cycle 2. A second edge during PULSE → second pulse exactly 8 cycles after the first falls. A third edge during the same window → ignored.
- Free play: `auto_coin`=1, joystick start held → one 8-cycle coin; `start_out[0]` stays 0 through GAP, rises the cycle FSM returns to IDLE.
- Autofire: `autofire_en[0]`=1, button 0 held 20 cycles → `btn_out[0]` 1 on cycle 1, toggling every 4 cycles; released → 0 next cycle.
- Reset: assert `I_RESETn`=0 during PULSE with a key held and `ps2_key[10]` flipped → all outputs 0; after release no spurious key or coin event.
